spi_dac_rx: RTL
===============

Name: spi_dac_rx

Overview:
SPI slave behavioural/synthesizable model of the MCP4911-style 10-bit DAC that the spi2dac master drives. It sits at the far end of DAC_SDI/DAC_SCK/DAC_CS/DAC_LD, deserialises each 16-bit frame, checks it, and holds the value in a two-stage input/output register pair. It is used for loopback self-test on the DE0 and as the checker in spi2dac benches. All logic runs on sysclk; the SPI pins are treated as asynchronous and oversampled.

Parameters:
FRAME_BITS, 16, bits per SPI frame (MSB first)
DATA_W, 10, DAC data width; occupies frame bits [11:2]
SYNC_STAGES, 2, flip-flop synchroniser depth on each SPI input (min 2)

Ports:
sysclk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
spi_sck  in  1  serial clock from master; data sampled on rising edge
spi_cs  in  1  chip select, active low
spi_sdi  in  1  serial data from master
spi_ld  in  1  load strobe, active low; falling edge transfers input reg to output reg
dac_out  out  DATA_W  output register (analogue value being "driven")
rx_data  out  DATA_W  input register (last good frame's data)
rx_cfg  out  3  last good frame's {BUF, nGA, nSHDN} = frame bits [14:12]
shdn  out  1  1 when output register was loaded while nSHDN=0
rx_valid  out  1  one-cycle pulse: good frame committed to input register
rx_error  out  1  one-cycle pulse: frame discarded
busy  out  1  1 while state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, shift reg 0, bit counter 0, synchroniser flops loaded with idle levels (sck=0, cs=1, sdi=0, ld=1) so no spurious edges after reset.
- All four inputs pass through SYNC_STAGES flops plus one edge-detect flop; equal depth keeps SDI aligned with SCK. Input timing requirement: SCK high and low times >= SYNC_STAGES+1 sysclk periods; SDI stable from rising SCK edge to >= 2 sysclk after it.
- States: IDLE, SHIFT, FULL.
- IDLE: synced CS falling -> SHIFT, bitcnt <= 0, shift reg <= 0. SCK edges in IDLE are ignored.
- SHIFT: each synced SCK rising edge: shift_reg <= {shift_reg[14:0], sdi}, bitcnt++; when bitcnt reaches FRAME_BITS -> FULL.
- FULL: further SCK rising edges set an overrun flag (frame will be rejected).
- CS rising in SHIFT or FULL -> IDLE, next cycle. Commit iff bitcnt == FRAME_BITS, no overrun, and frame bit15 (A/nB) == 0: rx_data <= frame[11:2], rx_cfg <= frame[14:12], rx_valid pulses 1 cycle. Otherwise rx_data/rx_cfg unchanged and rx_error pulses 1 cycle.
- Bits [1:0] are don't-care and ignored.
- Latency: CS rising pin edge -> rx_valid = SYNC_STAGES+2 sysclk cycles.
- LD: synced spi_ld falling edge (any state) -> dac_out <= rx_data, shdn <= ~rx_cfg[0], effective next cycle. Commit and LD falling in the same cycle: the newly committed data is loaded (bypass). LD held low does not repeat the load.
- SCK rising and CS rising in the same synced cycle: the SCK edge is counted first, then the CS rule is evaluated.
- Reset mid-frame: frame abandoned, no pulse; rx_data/dac_out return to 0.
- CS glitch (fall then rise with 0 bits): rx_error pulse.

Decomposition:
- Package spi_dac_pkg: FRAME_BITS, DATA_W, field bit positions (AB_BIT=15, BUF_BIT=14, NGA_BIT=13, NSHDN_BIT=12, DATA_MSB=11, DATA_LSB=2), state encoding.
- One sub-module, sync_edge: SYNC_STAGES synchroniser + rise/fall pulse outputs with a reset level parameter; instantiated four times.

Test Plan:
- Frame 0x7800 (cfg 111, data 0x200), CS high, then LD low pulse -> rx_valid once, rx_data=0x200, rx_cfg=3'b111, then dac_out=0x200, shdn=0.
- Frame 0x7FFC then 0x7000, LD after each -> dac_out 0x3FF then 0x000; two rx_valid pulses, no rx_error.
- Only 15 SCK edges before CS rises -> rx_error pulse, rx_data keeps previous 0x200; 17 edges -> rx_error (overrun).
- Frame 0xF800 (A/nB=1) -> rx_error, nothing committed; frame 0x6800 (nSHDN=0) then LD -> dac_out=0x200, shdn=1.
- Commit and LD falling forced into the same sysclk cycle -> dac_out takes the new frame's value the following cycle.
- Reset asserted after 8 SCK edges -> busy=0, no pulses, all outputs 0; next full frame 0x7004 commits rx_data=0x001.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// Shared constants, frame field positions and types for the MCP4911-style SPI DAC receiver.
package spi_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 10;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Frame layout, MSB first on the wire: {A/nB, BUF, nGA, nSHDN, D9..D0, x, x}
    localparam int AB_BIT    = 15;
    localparam int BUF_BIT   = 14;
    localparam int NGA_BIT   = 13;
    localparam int NSHDN_BIT = 12;
    localparam int DATA_MSB  = 11;
    localparam int DATA_LSB  = 2;

    localparam int PIN_SCK  = 0;
    localparam int PIN_CS   = 1;
    localparam int PIN_SDI  = 2;
    localparam int PIN_LD   = 3;
    localparam int NUM_PINS = 4;

    // Idle bus levels {ld, sdi, cs, sck}, loaded into the synchronisers on reset.
    localparam logic [NUM_PINS-1:0] PIN_IDLE = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } pin_sync_t;

endpackage

// File: rtl/spi_dac_rx_if.sv
// SPI pin bundle between the spi2dac master and the DAC receiver.
interface spi_dac_rx_if;
    logic spi_sck;
    logic spi_cs;
    logic spi_sdi;
    logic spi_ld;

    modport master (output spi_sck, output spi_cs, output spi_sdi, output spi_ld);
    modport slave  (input  spi_sck, input  spi_cs, input  spi_sdi, input  spi_ld);
endinterface

// File: rtl/spi_dac_rx_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin with registered level and edge pulses.
module sync_edge
    import spi_dac_pkg::*;
#(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic      sysclk,
    input  logic      reset,
    input  logic      din,
    output pin_sync_t q
);

    logic [STAGES-1:0] chain;

    // Level and pulses come from the same flop stage, so every pin sees identical delay.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            chain   <= {STAGES{RESET_LEVEL}};
            q.level <= RESET_LEVEL;
            q.rise  <= 1'b0;
            q.fall  <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], din};
            q.level <= chain[STAGES-1];
            q.rise  <= chain[STAGES-1] & ~q.level;
            q.fall  <= ~chain[STAGES-1] & q.level;
        end
    end

endmodule

// File: rtl/spi_dac_rx.sv
// SPI slave model of a 10-bit MCP4911-style DAC: deserialises, validates and double-buffers frames.
module spi_dac_rx
    import spi_dac_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              reset,
    spi_dac_rx_if.slave       spi,
    output logic [DATA_W-1:0] dac_out,
    output logic [DATA_W-1:0] rx_data,
    output logic [2:0]        rx_cfg,
    output logic              shdn,
    output logic              rx_valid,
    output logic              rx_error,
    output logic              busy
);

    logic [NUM_PINS-1:0] pins;
    pin_sync_t           syn [NUM_PINS];

    assign pins = {spi.spi_ld, spi.spi_sdi, spi.spi_cs, spi.spi_sck};

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_sync
        sync_edge #(
            .STAGES      (SYNC_STAGES),
            .RESET_LEVEL (PIN_IDLE[g])
        ) u_sync (
            .sysclk (sysclk),
            .reset  (reset),
            .din    (pins[g]),
            .q      (syn[g])
        );
    end

    logic sck_rise, cs_rise, cs_fall, ld_fall, sdi;
    assign sck_rise = syn[PIN_SCK].rise;
    assign cs_rise  = syn[PIN_CS].rise;
    assign cs_fall  = syn[PIN_CS].fall;
    assign ld_fall  = syn[PIN_LD].fall;
    assign sdi      = syn[PIN_SDI].level;

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg, shift_n;
    logic [CNT_W-1:0]      bitcnt, cnt_n;
    logic                  overrun, ovr_n;
    logic                  frame_ok, commit;

    // A same-cycle SCK edge is folded in before the CS-rise decision looks at the frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shift_n = shift_reg;
        cnt_n   = bitcnt;
        ovr_n   = overrun;
        if (sck_rise) begin
            if (state == ST_SHIFT) begin
                shift_n = {shift_reg[FRAME_BITS-2:0], sdi};
                cnt_n   = bitcnt + 1'b1;
            end else if (state == ST_FULL) begin
                ovr_n = 1'b1;
            end
        end
        frame_ok = (cnt_n == CNT_W'(FRAME_BITS)) && !ovr_n && !shift_n[AB_BIT];
        commit   = (state != ST_IDLE) && cs_rise && frame_ok;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            shift_reg <= '0;
            bitcnt    <= '0;
            overrun   <= 1'b0;
            rx_data   <= '0;
            rx_cfg    <= '0;
            rx_valid  <= 1'b0;
            rx_error  <= 1'b0;
            dac_out   <= '0;
            shdn      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_SHIFT;
                        busy      <= 1'b1;
                        shift_reg <= '0;
                        bitcnt    <= '0;
                        overrun   <= 1'b0;
                    end
                end
                default: begin
                    shift_reg <= shift_n;
                    bitcnt    <= cnt_n;
                    overrun   <= ovr_n;
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (frame_ok) begin
                            rx_data  <= shift_n[DATA_MSB:DATA_LSB];
                            rx_cfg   <= shift_n[BUF_BIT:NSHDN_BIT];
                            rx_valid <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                    end else if (cnt_n == CNT_W'(FRAME_BITS)) begin
                        state <= ST_FULL;
                    end
                end
            endcase
            // LD coinciding with a commit loads the frame being committed, not the stale input reg.
            if (ld_fall) begin
                dac_out <= commit ? shift_n[DATA_MSB:DATA_LSB] : rx_data;
                shdn    <= commit ? ~shift_n[NSHDN_BIT] : ~rx_cfg[0];
            end
        end
    end

endmodule
